// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with a double-buffered valid/ready load port.
// Build option: define SEG7_HEX_EN to decode codes 10..15 as hex glyphs A,b,C,d,E,F (otherwise they show E).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{SEG_ACTIVE_LOW}};

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic tick;
  logic frame_end;
  logic accept;
  logic xfer;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
`ifdef SEG7_HEX_EN
      4'd10:   s = 7'b1110111;
      4'd11:   s = 7'b0011111;
      4'd12:   s = 7'b1001110;
      4'd13:   s = 7'b0111101;
      4'd14:   s = 7'b1001111;
      default: s = 7'b1000111;
`else
      default: s = 7'b1001111;
`endif
    endcase
    return s;
  endfunction

  assign tick       = enable && (presc_q == PRE_LAST);
  assign frame_end  = tick && (idx_q == IDX_LAST);
  assign load_ready = !pending_q;
  assign accept     = load_valid && !pending_q;
  // While dark there is nothing to tear, so a waiting word is taken immediately.
  assign xfer       = pending_q && (frame_end || !enable);

  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;

    if (enable) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end

    if (accept) begin
      pend_d    = load_data;
      pending_d = 1'b1;
    end else if (xfer) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end
  end

  logic [3:0] cur_code;
  logic       cur_upper_zero;
  logic       run_zero;
  logic       blank;
  logic [6:0] seg_raw;
  logic [NUM_DIGITS-1:0] dig_raw;

  // Walk from the most significant digit down so run_zero means "this digit and all above are 0".
  always_comb begin
    cur_code       = 4'd0;
    cur_upper_zero = 1'b0;
    run_zero       = 1'b1;
    dig_raw        = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero && (disp_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        cur_code       = disp_q[4*k +: 4];
        cur_upper_zero = run_zero;
        dig_raw[k]     = 1'b1;
      end
    end

    blank   = blank_lz && cur_upper_zero && (idx_q != '0);
    seg_raw = blank ? 7'b0000000 : decode(cur_code);

    if (!enable) begin
      seg_raw = 7'b0000000;
      dig_raw = '0;
    end

    seg_d = seg_raw ^ SEG_OFF;
    dig_d = dig_raw ^ DIG_OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  assign seg_out = seg_q;
  assign dig_sel = dig_q;

endmodule
